// File: rtl/stage_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_pkg : shared types and the per-stage configuration table for the   |
// |             stage_sequencer game-flow controller.                        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package stage_pkg;

    localparam int NUM_STAGES_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_BANNER  = 3'd2,
        ST_PLAY    = 3'd3,
        ST_PAUSED  = 3'd4,
        ST_CLEARED = 3'd5,
        ST_WON     = 3'd6,
        ST_LOST    = 3'd7
    } state_t;

    typedef struct packed {
        logic [3:0] speed;
        logic [7:0] fire_period;
        logic [2:0] rows;
    } stage_cfg_t;

    // speed = k+1, fire_period = 120-30k, rows = min(k+2,5)
    localparam stage_cfg_t STAGE_TABLE [0:NUM_STAGES_MAX-1] = '{
        '{speed: 4'd1, fire_period: 8'd120, rows: 3'd2},
        '{speed: 4'd2, fire_period: 8'd90,  rows: 3'd3},
        '{speed: 4'd3, fire_period: 8'd60,  rows: 3'd4},
        '{speed: 4'd4, fire_period: 8'd30,  rows: 3'd5}
    };

    function automatic logic [3:0] sat_add_speed(input logic [3:0] speed, input logic [1:0] bonus);
        logic [4:0] sum;
        sum = {1'b0, speed} + {3'b000, bonus};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_sequencer_if : game events in, stage config / phase status out.    |
// | STAGE_SEQ_ENDLESS_EN adds the loop_cnt status signal.                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface stage_sequencer_if;
    logic       start_game;
    logic       pause;
    logic       stage_cleared;
    logic       player_destroyed;
    logic [1:0] stage_num;
    logic [3:0] monster_speed;
    logic [7:0] fire_period;
    logic [2:0] monster_rows;
    logic       resetN_monsters;
    logic       enable_play;
    logic       show_banner;
    logic       last_stage;
    logic       game_won;
    logic       game_over;
`ifdef STAGE_SEQ_ENDLESS_EN
    logic [1:0] loop_cnt;

    modport master (
        output start_game, pause, stage_cleared, player_destroyed,
        input  stage_num, monster_speed, fire_period, monster_rows, resetN_monsters,
        input  enable_play, show_banner, last_stage, game_won, game_over, loop_cnt
    );
    modport slave (
        input  start_game, pause, stage_cleared, player_destroyed,
        output stage_num, monster_speed, fire_period, monster_rows, resetN_monsters,
        output enable_play, show_banner, last_stage, game_won, game_over, loop_cnt
    );
`else
    modport master (
        output start_game, pause, stage_cleared, player_destroyed,
        input  stage_num, monster_speed, fire_period, monster_rows, resetN_monsters,
        input  enable_play, show_banner, last_stage, game_won, game_over
    );
    modport slave (
        input  start_game, pause, stage_cleared, player_destroyed,
        output stage_num, monster_speed, fire_period, monster_rows, resetN_monsters,
        output enable_play, show_banner, last_stage, game_won, game_over
    );
`endif
endinterface
`default_nettype wire

// File: rtl/stage_sequencer_tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_divider : free-running divider emitting a one-cycle tick every      |
// |                CLK_PER_TICK cycles of run; clear restarts the period.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tick_divider #(
    parameter int CLK_PER_TICK = 31500000
) (
    input  wire logic clk,
    input  wire logic resetN,
    input  wire logic clear,
    input  wire logic run,
    output logic      tick
);
    localparam int            CW       = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_TICK - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    assign tick   = run && w_wrap;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_sequencer : game-flow FSM (load/banner/play/pause/cleared/win/lose)|
// |                   driving per-stage config. Option: STAGE_SEQ_ENDLESS_EN |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int CLK_PER_TICK = 31500000,
    parameter int BANNER_TICKS = 2
) (
    input  wire logic        clk,
    input  wire logic        resetN,
    stage_sequencer_if.slave bus
);
    localparam int             BCW         = (BANNER_TICKS > 1) ? $clog2(BANNER_TICKS) : 1;
    localparam logic [BCW-1:0] BANNER_LAST = BCW'(BANNER_TICKS - 1);
    localparam logic [1:0]     LAST_STAGE  = 2'(NUM_STAGES - 1);

    state_t         r_state, w_next_state;
    logic [1:0]     r_stage_num, w_next_stage;
    logic [BCW-1:0] r_banner_cnt;
    stage_cfg_t     r_cfg, w_next_cfg;
    logic           r_resetN_monsters, r_enable_play, r_show_banner, r_game_won, r_game_over;
    logic           w_resetN_monsters, w_enable_play, w_show_banner, w_game_won, w_game_over;
    logic           w_tick, w_last_stage;
`ifdef STAGE_SEQ_ENDLESS_EN
    logic [1:0]     r_loop_cnt, w_next_loop;
`endif

    tick_divider #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
        .clk    (clk),
        .resetN (resetN),
        .clear  (r_state == ST_LOAD),
        .run    (r_state == ST_BANNER),
        .tick   (w_tick)
    );

    assign w_last_stage = (r_stage_num == LAST_STAGE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state           <= ST_IDLE;
            r_stage_num       <= '0;
            r_banner_cnt      <= '0;
            r_cfg             <= STAGE_TABLE[0];
            r_resetN_monsters <= 1'b1;
            r_enable_play     <= 1'b0;
            r_show_banner     <= 1'b0;
            r_game_won        <= 1'b0;
            r_game_over       <= 1'b0;
`ifdef STAGE_SEQ_ENDLESS_EN
            r_loop_cnt        <= '0;
`endif
        end else begin
            r_state           <= w_next_state;
            r_stage_num       <= w_next_stage;
            r_cfg             <= w_next_cfg;
            r_resetN_monsters <= w_resetN_monsters;
            r_enable_play     <= w_enable_play;
            r_show_banner     <= w_show_banner;
            r_game_won        <= w_game_won;
            r_game_over       <= w_game_over;
`ifdef STAGE_SEQ_ENDLESS_EN
            r_loop_cnt        <= w_next_loop;
`endif
            if (r_state == ST_LOAD) begin
                r_banner_cnt <= '0;
            end else if (r_state == ST_BANNER && w_tick) begin
                r_banner_cnt <= r_banner_cnt + BCW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_stage = r_stage_num;
`ifdef STAGE_SEQ_ENDLESS_EN
        w_next_loop  = r_loop_cnt;
`endif
        case (r_state)
            ST_IDLE, ST_WON, ST_LOST: begin
                if (bus.start_game) begin
                    w_next_state = ST_LOAD;
                    w_next_stage = '0;
`ifdef STAGE_SEQ_ENDLESS_EN
                    w_next_loop  = '0;
`endif
                end
            end
            ST_LOAD: w_next_state = ST_BANNER;
            ST_BANNER: begin
                if (w_tick && r_banner_cnt == BANNER_LAST) w_next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.player_destroyed)   w_next_state = ST_LOST;
                else if (bus.stage_cleared) w_next_state = ST_CLEARED;
                else if (bus.pause)         w_next_state = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!bus.pause) w_next_state = ST_PLAY;
            end
            ST_CLEARED: begin
                if (w_last_stage) begin
`ifdef STAGE_SEQ_ENDLESS_EN
                    w_next_state = ST_LOAD;
                    w_next_stage = '0;
                    w_next_loop  = (r_loop_cnt == 2'd3) ? 2'd3 : r_loop_cnt + 2'd1;
`else
                    w_next_state = ST_WON;
`endif
                end else begin
                    w_next_state = ST_LOAD;
                    w_next_stage = r_stage_num + 2'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decode the state being entered so the registered copies line up with r_state.
    always_comb begin
        w_resetN_monsters = (w_next_state != ST_LOAD);
        w_show_banner     = (w_next_state == ST_BANNER);
        w_enable_play     = (w_next_state == ST_PLAY);
        w_game_won        = (w_next_state == ST_WON);
        w_game_over       = (w_next_state == ST_LOST);
        w_next_cfg        = r_cfg;
        if (w_next_state == ST_LOAD) begin
            w_next_cfg = STAGE_TABLE[w_next_stage];
`ifdef STAGE_SEQ_ENDLESS_EN
            w_next_cfg.speed = sat_add_speed(STAGE_TABLE[w_next_stage].speed, w_next_loop);
`endif
        end
    end

    assign bus.stage_num       = r_stage_num;
    assign bus.monster_speed   = r_cfg.speed;
    assign bus.fire_period     = r_cfg.fire_period;
    assign bus.monster_rows    = r_cfg.rows;
    assign bus.resetN_monsters = r_resetN_monsters;
    assign bus.enable_play     = r_enable_play;
    assign bus.show_banner     = r_show_banner;
    assign bus.last_stage      = w_last_stage;
    assign bus.game_won        = r_game_won;
    assign bus.game_over       = r_game_over;
`ifdef STAGE_SEQ_ENDLESS_EN
    assign bus.loop_cnt        = r_loop_cnt;
`endif
endmodule
`default_nettype wire
